timer_mode_ctrl: RTL and testbench

Mode controller for the 60 s stopwatch/countdown timer datapath. It synchronises and debounces the six active-low front-panel keys and runs the up/down/pause/alarm state machine. It drives single-cycle load and clear commands plus level run/direction/precision controls into the counter, and owns the alarm LED. It sits between the board keys and the counter/7-segment datapath, in the 50 MHz domain.

---
 rtl/timer_ctrl_pkg.sv | 20 ++
 rtl/key_conditioner.sv | 39 +++
 rtl/timer_mode_ctrl.sv | 95 +++++++++
 tb/tb_timer_mode_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: state encoding, key indices and BCD clamp limits for timer_mode_ctrl
package timer_ctrl_pkg;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RUN_UP   = 3'd1;
  localparam logic [2:0] S_RUN_DN   = 3'd2;
  localparam logic [2:0] S_PAUSE_UP = 3'd3;
  localparam logic [2:0] S_PAUSE_DN = 3'd4;
  localparam logic [2:0] S_ALARM    = 3'd5;
  localparam int K_UP    = 0;
  localparam int K_DN    = 1;
  localparam int K_STOP  = 2;
  localparam int K_PAUSE = 4;
  localparam int K_LOAD  = 5;
  localparam int K_PREC  = 6;
  localparam logic [3:0] TEN_MAX = 4'd5;
  localparam logic [3:0] ONE_MAX = 4'd9;
  function automatic logic [3:0] bcd_clamp(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/key_conditioner.sv
// key_conditioner: 2-flop sync, optional debounce (TIMER_CTRL_DEBOUNCE_EN), one-cycle press pulse
module key_conditioner #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  logic [1:0] sync;
  logic level, level_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], key_n};
`ifdef TIMER_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] cnt;
  // level only follows sync after it has disagreed for DB_CYCLES consecutive cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync[1] == level) cnt <= '0;
    else if (cnt == CW'(DB_CYCLES - 1)) begin
      level <= sync[1];
      cnt   <= '0;
    end else cnt <= cnt + 1'b1;
`else
  assign level = sync[1];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level_q <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level_q & ~level;
    end
endmodule

// File: rtl/timer_mode_ctrl.sv
// timer_mode_ctrl: key conditioning plus up/down/pause/alarm FSM for the 60 s timer datapath
// Debounce is present only when TIMER_CTRL_DEBOUNCE_EN is defined.
module timer_mode_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int DB_CYCLES    = 1_000_000,
  parameter int ALARM_CYCLES = 150_000_000
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       en,
  input  logic       key0,
  input  logic       key1,
  input  logic       key2,
  input  logic       key4,
  input  logic       key5,
  input  logic       key6,
  input  logic [3:0] ten,
  input  logic [3:0] one,
  input  logic       zero,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       load,
  output logic [3:0] load_ten,
  output logic [3:0] load_one,
  output logic       clr,
  output logic       prec,
  output logic       led,
  output logic [2:0] state
);
  localparam int AW = $clog2(ALARM_CYCLES);
  logic [5:0] keys;
  logic [6:0] press, ev;
  logic [2:0] nxt;
  logic do_clr, do_load, nprec;
  logic [3:0] c_ten, c_one;
  logic [AW-1:0] acnt;
  assign keys  = {key6, key5, key4, key2, key1, key0};
  assign press[3] = 1'b0;
  for (genvar i = 0; i < 6; i++) begin : g_key
    key_conditioner #(.DB_CYCLES(DB_CYCLES)) u_kc (
      .clk(clk_50M), .rst(rst), .key_n(keys[i]), .press(press[i < 3 ? i : i + 1])
    );
  end
  assign ev    = en ? press : '0;
  assign c_ten = bcd_clamp(ten, TEN_MAX);
  assign c_one = bcd_clamp(one, ONE_MAX);
  // only the highest-priority event is acted on; zero and the alarm timeout are levels
  always_comb begin
    nxt     = state;
    do_clr  = 1'b0;
    do_load = 1'b0;
    nprec   = prec;
    if (ev[K_STOP]) begin
      nxt    = S_IDLE;
      do_clr = 1'b1;
    end else if (ev[K_DN]) begin
      do_load = state != S_ALARM;
      nxt     = (state == S_ALARM) ? state : (c_ten == 4'd0 && c_one == 4'd0) ? S_ALARM : S_RUN_DN;
    end else if (ev[K_UP]) begin
      do_clr = state != S_ALARM;
      nxt    = (state == S_ALARM) ? state : S_RUN_UP;
    end else if (ev[K_LOAD]) do_load = state == S_IDLE || state == S_PAUSE_UP || state == S_PAUSE_DN;
    else if (ev[K_PAUSE])
      nxt = (state == S_RUN_UP) ? S_PAUSE_UP : (state == S_PAUSE_UP) ? S_RUN_UP :
            (state == S_RUN_DN) ? S_PAUSE_DN : (state == S_PAUSE_DN) ? S_RUN_DN : state;
    else if (ev[K_PREC]) nprec = (state == S_ALARM) ? prec : ~prec;
    if (en && zero && state == S_RUN_DN && nxt == S_RUN_DN && !do_load) nxt = S_ALARM;
    if (en && state == S_ALARM && !ev[K_STOP] && acnt == AW'(ALARM_CYCLES - 1)) nxt = S_IDLE;
  end
  always_ff @(posedge clk_50M or posedge rst)
    if (rst) begin
      state    <= S_IDLE;
      cnt_en   <= 1'b0;
      cnt_up   <= 1'b1;
      load     <= 1'b0;
      clr      <= 1'b0;
      prec     <= 1'b0;
      led      <= 1'b0;
      load_ten <= 4'd0;
      load_one <= 4'd0;
      acnt     <= '0;
    end else begin
      state    <= nxt;
      cnt_en   <= en && (nxt == S_RUN_UP || nxt == S_RUN_DN);
      cnt_up   <= nxt == S_RUN_UP || nxt == S_PAUSE_UP;
      load     <= do_load;
      clr      <= do_clr;
      prec     <= nprec;
      led      <= nxt == S_ALARM;
      load_ten <= c_ten;
      load_one <= c_one;
      acnt     <= (state != S_ALARM) ? '0 : en ? acnt + 1'b1 : acnt;
    end
endmodule

// File: tb/tb_timer_mode_ctrl.sv
// tb_timer_mode_ctrl: randomized key presses checked against an event-level model of the timer controller
module tb_timer_mode_ctrl;
  localparam int DB = 4, AC = 20;
  localparam int IDLE = 0, RUN_UP = 1, RUN_DN = 2, PAUSE_UP = 3, PAUSE_DN = 4, ALARM = 5;
  logic clk_50M = 1'b0, rst = 1'b0, en = 1'b1, zero = 1'b0;
  logic key0 = 1'b1, key1 = 1'b1, key2 = 1'b1, key4 = 1'b1, key5 = 1'b1, key6 = 1'b1;
  logic [3:0] ten = 4'd0, one = 4'd0;
  logic cnt_en, cnt_up, load, clr, prec, led;
  logic [3:0] load_ten, load_one;
  logic [2:0] state;
  int n_vec = 0, n_bad = 0;
  int m_state, m_prec, m_led, e_clr, e_load;
  bit mon = 0;
  int n_clr, n_load, p_state;

  timer_mode_ctrl #(.DB_CYCLES(DB), .ALARM_CYCLES(AC)) dut (
    .clk_50M(clk_50M), .rst(rst), .en(en), .key0(key0), .key1(key1), .key2(key2),
    .key4(key4), .key5(key5), .key6(key6), .ten(ten), .one(one), .zero(zero),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .load(load), .load_ten(load_ten), .load_one(load_one),
    .clr(clr), .prec(prec), .led(led), .state(state)
  );

  always #5 clk_50M = ~clk_50M;

  always @(negedge clk_50M)
    if (mon) begin
      n_clr  += int'(clr);
      n_load += int'(load);
      if (clr || load) p_state = int'(state);
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic set_keys(input bit [6:0] m);
    key0 = ~m[0]; key1 = ~m[1]; key2 = ~m[2]; key4 = ~m[4]; key5 = ~m[5]; key6 = ~m[6];
  endtask

  task automatic press(input bit [6:0] m, input int hold);
    n_clr = 0; n_load = 0; p_state = -1; mon = 1;
    set_keys(m);
    cyc(hold);
    set_keys(7'd0);
    cyc(8);
    mon = 0;
  endtask

  task automatic model_keys(input bit [6:0] m);
    int pri[6] = '{2, 1, 0, 5, 4, 6};
    int k = -1;
    e_clr = 0; e_load = 0;
    for (int i = 0; i < 6; i++) if (k < 0 && m[pri[i]]) k = pri[i];
    if (k == 2) begin m_state = IDLE; m_led = 0; e_clr = 1; end
    else if (m_state == ALARM || k < 0) begin end
    else if (k == 0) begin e_clr = 1; m_state = RUN_UP; end
    else if (k == 1) begin
      e_load = 1;
      m_state = (ten == 0 && one == 0) ? ALARM : RUN_DN;
      m_led = (m_state == ALARM);
    end
    else if (k == 5) e_load = (m_state == IDLE || m_state == PAUSE_UP || m_state == PAUSE_DN) ? 1 : 0;
    else if (k == 4) begin
      case (m_state)
        RUN_UP:   m_state = PAUSE_UP;
        PAUSE_UP: m_state = RUN_UP;
        RUN_DN:   m_state = PAUSE_DN;
        PAUSE_DN: m_state = RUN_DN;
        default:  m_state = m_state;
      endcase
    end
    else if (k == 6) m_prec ^= 1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, state, m_state);
    check({tag, ".cnt_en"}, cnt_en, (en && (m_state == RUN_UP || m_state == RUN_DN)) ? 1 : 0);
    check({tag, ".cnt_up"}, cnt_up, (m_state == RUN_UP || m_state == PAUSE_UP) ? 1 : 0);
    check({tag, ".prec"}, prec, m_prec);
    check({tag, ".led"}, led, m_led);
    check({tag, ".clr_cycles"}, n_clr, e_clr);
    check({tag, ".load_cycles"}, n_load, e_load);
    if (e_clr + e_load > 0) check({tag, ".pulse_state"}, p_state, m_state);
  endtask

  task automatic key_step(input bit [6:0] m, input string tag);
    press(m, 10);
    model_keys(m);
    check_all(tag);
  endtask

  task automatic wait_alarm_out(input string tag);
    cyc(AC + 5);
    m_state = IDLE; m_led = 0;
    check({tag, ".timeout_state"}, state, IDLE);
    check({tag, ".timeout_led"}, led, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lit, k, keys_l[6];
    keys_l = '{0, 1, 2, 4, 5, 6};
    #2 rst = 1'b1;
    cyc(3);
    check("rst.state", state, IDLE);
    check("rst.cnt_en", cnt_en, 0);
    check("rst.cnt_up", cnt_up, 1);
    check("rst.load", load, 0);
    check("rst.clr", clr, 0);
    check("rst.prec", prec, 0);
    check("rst.led", led, 0);
    check("rst.load_ten", load_ten, 0);
    check("rst.load_one", load_one, 0);
    rst = 1'b0;
    m_state = IDLE; m_prec = 0; m_led = 0;
    cyc(3);

    key_step(7'b0000001, "up");
    ten = 4'd1; one = 4'd5;
    cyc(2);
    check("preset.ten", load_ten, 1);
    check("preset.one", load_one, 5);
    key_step(7'b0000010, "dn");
    zero = 1'b1;
    cyc(1);
    zero = 1'b0;
    check("zero.state", state, ALARM);
    check("zero.cnt_en", cnt_en, 0);
    check("zero.led", led, 1);
    lit = 1;
    for (int i = 0; i < 100 && led === 1'b1; i++) begin
      cyc(1);
      if (led === 1'b1) lit++;
    end
    check("alarm.led_cycles", lit, AC);
    check("alarm.end_state", state, IDLE);
    m_state = IDLE; m_led = 0;

    ten = 4'd7; one = 4'd12;
    cyc(2);
    check("clamp.ten", load_ten, 5);
    check("clamp.one", load_one, 9);
    ten = 4'd0; one = 4'd0;
    cyc(2);
    key_step(7'b0000010, "dn00");
    wait_alarm_out("dn00");

    key_step(7'b0000001, "up2");
    key_step(7'b0010000, "pause");
    key_step(7'b0010000, "resume");
    key_step(7'b1000000, "prec");
    key_step(7'b0000101, "stop_wins");
    key_step(7'b0000001, "up3");
    press(7'b0010000, 2);
`ifdef TIMER_CTRL_DEBOUNCE_EN
    model_keys(7'd0);
`else
    model_keys(7'b0010000);
`endif
    check_all("glitch");

    ten = 4'd2; one = 4'd3;
    key_step(7'b0000010, "dn2");
    en = 1'b0;
    cyc(2);
    check("en0.cnt_en", cnt_en, 0);
    press(7'b0010000, 10);
    model_keys(7'd0);
    check_all("en0.key4");
    en = 1'b1;
    cyc(2);
    check_all("en1");

    for (int it = 0; it < 40; it++) begin
      k = keys_l[$urandom_range(0, 5)];
      ten = 4'($urandom_range(0, 15));
      one = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin ten = 4'd0; one = 4'd0; end
      cyc(2);
      check("rnd.load_ten", load_ten, (ten > 5) ? 5 : ten);
      check("rnd.load_one", load_one, (one > 9) ? 9 : one);
      key_step(7'(1 << k), $sformatf("rnd%0d.k%0d", it, k));
      if (m_state == ALARM) wait_alarm_out("rnd");
    end

    ten = 4'd0; one = 4'd0;
    cyc(2);
    key_step(7'b0000010, "pre_rst");
    #2 rst = 1'b1;
    #1;
    check("async_rst.led", led, 0);
    check("async_rst.state", state, IDLE);
    check("async_rst.cnt_en", cnt_en, 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
